// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I instruction fetch: PC sequencing, imem handshake, prefetch FIFO
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstB,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        inst_valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count_q, fifo_count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic          imem_req_q, imem_req_d;
    logic [31:0]   instruction_q, instruction_d;
    logic [31:0]   pc_out_q, pc_out_d;
    logic          inst_valid_q, inst_valid_d;
    logic          redirect, issue, resp, push, pop;
    logic [CW:0]   credit_d;

    always_comb begin
        redirect = jmp && (state_q != IDLE);
        issue    = imem_req_q && imem_gnt;
        resp     = imem_rvalid && (state_q != IDLE);
        push     = resp && (state_q == FETCH) && !redirect;
        pop      = !stall && !redirect && (fifo_count_q != '0);

        state_d       = state_q;
        fetch_pc_d    = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d     = push ? resp_pc_q + 32'd4 : resp_pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
        discard_d     = discard_q;
        fifo_count_d  = fifo_count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        instruction_d = instruction_q;
        pc_out_d      = pc_out_q;
        inst_valid_d  = inst_valid_q;

        if (pop) begin
            instruction_d = fifo_data_q[rd_ptr_q];
            pc_out_d      = fifo_pc_q[rd_ptr_q];
            inst_valid_d  = 1'b1;
        end else if (!stall) begin
            instruction_d = '0;
            inst_valid_d  = 1'b0;
        end

        case (state_q)
            IDLE:  state_d = FETCH;
            FLUSH: begin
                if (resp) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) state_d = FETCH;
                end
            end
            default: ;
        endcase

        // Everything granted and not yet returned by the end of J is stale.
        if (redirect) begin
            fetch_pc_d    = {jmp_addr[31:2], 2'b00};
            resp_pc_d     = {jmp_addr[31:2], 2'b00};
            fifo_count_d  = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            instruction_d = '0;
            pc_out_d      = '0;
            inst_valid_d  = 1'b0;
            discard_d     = outstanding_d;
            state_d       = (outstanding_d != '0) ? FLUSH : FETCH;
        end

        credit_d   = {1'b0, fifo_count_d} + {1'b0, outstanding_d};
        imem_req_d = (state_d == FETCH) && (credit_d < {1'b0, DEPTH_C});
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_count_q  <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            imem_req_q    <= 1'b0;
            instruction_q <= '0;
            pc_out_q      <= '0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_count_q  <= fifo_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            imem_req_q    <= imem_req_d;
            instruction_q <= instruction_d;
            pc_out_q      <= pc_out_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rstB) begin
            assert (outstanding_q <= DEPTH_C);
            assert (fifo_count_q <= DEPTH_C);
            assert (!(push && !pop && (fifo_count_q == DEPTH_C)));
        end
    end

    assign imem_req        = imem_req_q;
    assign imem_addr       = fetch_pc_q;
    assign instruction_out = instruction_q;
    assign pc_out          = pc_out_q;
    assign inst_valid      = inst_valid_q;
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized bench for inst_fetch against an in-order memory and PC-stream model
module tb_inst_fetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rstB, stall, jmp, imem_gnt, imem_rvalid;
    logic [31:0] jmp_addr, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, instruction_out, pc_out;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstB(rstB), .stall(stall), .jmp(jmp), .jmp_addr(jmp_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction_out(instruction_out), .pc_out(pc_out), .inst_valid(inst_valid)
    );

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t        mem_q[$];
    logic [31:0] seen_q[$];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, gnt_pct = 100, lat_min = 1, lat_max = 1;
    int stale = 0, first_valid = -1, n_valid = 0, rand_valid = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        prev_rst = 1'b0, prev_stall = 1'b0, prev_jmp = 1'b0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_valid = 1'b0;
    logic [31:0] prev_addr = '0, prev_inst = '0, prev_pc = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] seen_at(input int i);
        return (seen_q.size() > i) ? seen_q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check_reset_outputs();
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_inst", instruction_out, '0);
        check_eq("rst_pc", pc_out, '0);
        check_eq("rst_valid", inst_valid, 1'b0);
    endtask

    // One clock cycle: check the visible outputs, drive this cycle's inputs, advance the model.
    task automatic tick();
        logic granted;
        if (prev_rst && prev_jmp) begin
            check_eq("jmp_valid_clr", inst_valid, 1'b0);
            check_eq("jmp_pc_clr", pc_out, '0);
            check_eq("jmp_inst_clr", instruction_out, '0);
        end else if (prev_rst && prev_stall) begin
            check_eq("stall_hold_valid", inst_valid, prev_valid);
            check_eq("stall_hold_inst", instruction_out, prev_inst);
            check_eq("stall_hold_pc", pc_out, prev_pc);
        end else if (inst_valid) begin
            check_eq("pc_out", pc_out, exp_pc);
            check_eq("instruction_out", instruction_out, exp_pc ^ KEY);
            seen_q.push_back(pc_out);
            if (first_valid < 0) first_valid = cyc;
            n_valid++;
            exp_pc += 32'd4;
        end
        if (stale > 0) check_eq("flush_no_req", imem_req, 1'b0);
        if (prev_rst && prev_req && !prev_gnt && !prev_jmp && imem_req)
            check_eq("addr_stable", imem_addr, prev_addr);

        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (rstB && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        granted = imem_req && imem_gnt;

        if (!rstB) begin
            mem_q.delete();
            seen_q.delete();
            stale  = 0;
            exp_pc = RESET_PC;
        end else begin
            if (imem_rvalid) void'(mem_q.pop_front());
            if (granted) mem_q.push_back('{imem_addr, cyc + $urandom_range(lat_max, lat_min)});
            if (jmp) begin
                stale  = mem_q.size();
                exp_pc = {jmp_addr[31:2], 2'b00};
                seen_q.delete();
            end else if (imem_rvalid && stale > 0) begin
                stale--;
            end
        end

        prev_rst = rstB; prev_stall = stall; prev_jmp = jmp;
        prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
        prev_valid = inst_valid; prev_inst = instruction_out; prev_pc = pc_out;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rstB = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset and continuous stream with zero-wait memory.
        tick(); tick();
        check_reset_outputs();
        rstB = 1'b1; cyc = 0; first_valid = -1; n_valid = 0;
        check_eq("idle_no_req", imem_req, 1'b0);
        tick();
        check_eq("c1_req", imem_req, 1'b1);
        check_eq("c1_addr", imem_addr, RESET_PC);
        repeat (23) tick();
        check_eq("first_valid_cycle", first_valid, 4);
        check_eq("stream_rate", n_valid, 20);

        // Stall long enough for the FIFO to fill and requests to stop.
        stall = 1'b1;
        repeat (4) tick();
        check_eq("stall_full_no_req", imem_req, 1'b0);
        check_eq("stall_valid_held", inst_valid, 1'b1);
        tick();
        stall = 1'b0;
        repeat (10) tick();

        // Redirect with fetches in flight.
        lat_min = 3; lat_max = 3;
        repeat (12) tick();
        jmp = 1'b1; jmp_addr = 32'h0000_0103;
        tick();
        jmp = 1'b0;
        check_eq("jmp_flush_req", imem_req, 1'b0);
        repeat (15) tick();
        check_eq("jmp_first_pc", seen_at(0), 32'h0000_0100);

        // Back-to-back redirect, the second landing in FLUSH; then jmp under stall.
        repeat (8) tick();
        jmp = 1'b1; jmp_addr = 32'h0000_0180;
        tick();
        jmp_addr = 32'h0000_0200;
        tick();
        jmp = 1'b0;
        repeat (15) tick();
        check_eq("b2b_first_pc", seen_at(0), 32'h0000_0200);
        stall = 1'b1; jmp = 1'b1; jmp_addr = 32'h0000_0240;
        tick();
        jmp = 1'b0;
        check_eq("jmp_stall_valid", inst_valid, 1'b0);
        stall = 1'b0;
        repeat (15) tick();

        // Clean redirect: nothing in flight, check J+1 request and J+4 output.
        lat_min = 1; lat_max = 1; gnt_pct = 0;
        repeat (8) tick();
        jmp = 1'b1; jmp_addr = 32'h0000_0300;
        tick();
        jmp = 1'b0; gnt_pct = 100;
        check_eq("redir_req", imem_req, 1'b1);
        check_eq("redir_addr", imem_addr, 32'h0000_0300);
        repeat (3) tick();
        check_eq("redir_valid_j4", inst_valid, 1'b1);
        check_eq("redir_pc_j4", pc_out, 32'h0000_0300);

        // Fetch PC wrap.
        repeat (4) tick();
        jmp = 1'b1; jmp_addr = 32'hFFFF_FFF8;
        tick();
        jmp = 1'b0;
        repeat (10) tick();
        check_eq("wrap_pc0", seen_at(0), 32'hFFFF_FFF8);
        check_eq("wrap_pc1", seen_at(1), 32'hFFFF_FFFC);
        check_eq("wrap_pc2", seen_at(2), 32'h0000_0000);

        // Random grant gaps, latencies, stalls and redirects.
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        rand_valid = n_valid;
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(99) < 20);
            jmp      = ($urandom_range(99) < 4);
            jmp_addr = $urandom;
            tick();
        end
        stall = 1'b0; jmp = 1'b0;
        repeat (20) tick();
        check_eq("random_progress", (n_valid - rand_valid) > 50, 1'b1);

        // Reset mid-operation with fetches outstanding.
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        repeat (10) tick();
        rstB = 1'b0;
        tick();
        check_reset_outputs();
        rstB = 1'b1;
        check_eq("rerst_idle_req", imem_req, 1'b0);
        tick();
        check_eq("rerst_req", imem_req, 1'b1);
        check_eq("rerst_addr", imem_addr, RESET_PC);
        repeat (14) tick();
        check_eq("rerst_first_pc", seen_at(0), RESET_PC);
        check_eq("rerst_second_pc", seen_at(1), RESET_PC + 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
